// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared state encoding and slice width for the nibble-serial adder sequencer.
package nibble_serial_adder_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Requester-side bus of the nibble-serial adder: start/clear handshake, operands and result.
interface nibble_serial_adder_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             clear;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;

    modport master (
        output start, clear, a, b, carry_in,
        input  ready, busy, done, sum, carry_out
    );

    modport slave (
        input  start, clear, a, b, carry_in,
        output ready, busy, done, sum, carry_out
    );
endinterface

// File: rtl/nibble_serial_adder_ctrl_nibble_adder.sv
// Combinational 4-bit adder slice with carry in and carry out.
module nibble_adder
    import nibble_serial_adder_ctrl_pkg::*;
(
    input  logic [NIBBLE_W-1:0] i_x,
    input  logic [NIBBLE_W-1:0] i_y,
    input  logic                i_ci,
    output logic [NIBBLE_W-1:0] o_s,
    output logic                o_co
);
    assign {o_co, o_s} = {1'b0, i_x} + {1'b0, i_y} + {{NIBBLE_W{1'b0}}, i_ci};
endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit add performed one nibble per clock through a single shared 4-bit slice.
module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    nibble_serial_adder_ctrl_if.slave bus
);
    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [WIDTH-1:0]    r_sum;
    logic                r_carry;
    logic                r_carry_out;
    logic [IDX_W-1:0]    r_idx;
    logic                r_ready;
    logic                r_busy;
    logic                r_done;
    logic [NIBBLE_W-1:0] w_x;
    logic [NIBBLE_W-1:0] w_y;
    logic [NIBBLE_W-1:0] w_s;
    logic                w_co;
    logic                w_last;

    assign w_x    = r_a[r_idx*NIBBLE_W +: NIBBLE_W];
    assign w_y    = r_b[r_idx*NIBBLE_W +: NIBBLE_W];
    assign w_last = (r_idx == LAST_IDX);

    nibble_adder u_slice (
        .i_x  (w_x),
        .i_y  (w_y),
        .i_ci (r_carry),
        .o_s  (w_s),
        .o_co (w_co)
    );

    // Next-state decode; clear overrides every transition, including an accepted start.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_next_state = ST_RUN;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
        if (bus.clear) begin
            w_next_state = ST_IDLE;
        end else begin
            w_next_state = w_next_state;
        end
    end

    // State register with status flags registered from the next state so they track it exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_ready <= (w_next_state == ST_IDLE);
            r_busy  <= (w_next_state == ST_RUN);
            r_done  <= (w_next_state == ST_DONE);
        end
    end

    // Operand capture and nibble stepping; clear freezes the result at its partial value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_carry_out <= 1'b0;
            r_idx       <= '0;
        end else if (!bus.clear) begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_a         <= bus.a;
                        r_b         <= bus.b;
                        r_carry     <= bus.carry_in;
                        r_sum       <= '0;
                        r_carry_out <= 1'b0;
                        r_idx       <= '0;
                    end
                end
                ST_RUN: begin
                    r_sum[r_idx*NIBBLE_W +: NIBBLE_W] <= w_s;
                    r_carry <= w_co;
                    r_idx   <= w_last ? '0 : r_idx + 1'b1;
                    if (w_last) begin
                        r_carry_out <= w_co;
                    end
                end
                default: begin
                    r_idx <= r_idx;
                end
            endcase
        end
    end

    assign bus.ready     = r_ready;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.sum       = r_sum;
    assign bus.carry_out = r_carry_out;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for the nibble-serial adder sequencer at WIDTH=16 with hand-computed results.
module tb_nibble_serial_adder_ctrl;
    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;
    int   d0;
    bit   mon_en   = 1'b0;

    nibble_serial_adder_ctrl_if #(.WIDTH(16)) bus ();

    nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ready/busy/done must be one-hot every cycle; also count done pulses
    always @(negedge clk) begin
        if (mon_en) begin
            check("onehot", 32'($countones({bus.ready, bus.busy, bus.done})), 32'd1);
        end
        if (bus.done === 1'b1) done_cnt++;
    end

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                          input logic [15:0] es, input logic ec, input string tag);
        bus.a = ta; bus.b = tb_v; bus.carry_in = tc; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check({tag, "_busy"}, 32'(bus.busy), 32'd1);
            tick();
        end
        check({tag, "_done"}, 32'(bus.done), 32'd1);
        check({tag, "_sum"}, 32'(bus.sum), 32'(es));
        check({tag, "_cout"}, 32'(bus.carry_out), 32'(ec));
        tick();
        check({tag, "_ready_after"}, 32'(bus.ready), 32'd1);
        check({tag, "_done_after"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0; bus.clear = 1'b0;
        bus.a = 16'h0000; bus.b = 16'h0000; bus.carry_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_cout", 32'(bus.carry_out), 32'd0);

        run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, "wrap");

        run_op(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, "cin");
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_sum", 32'(bus.sum), 32'h5556);
            check("hold_cout", 32'(bus.carry_out), 32'd0);
        end

        // start kept high with new operands during RUN and DONE must be ignored
        d0 = done_cnt;
        bus.a = 16'h0F0F; bus.b = 16'h0101; bus.carry_in = 1'b0; bus.start = 1'b1;
        tick();
        bus.a = 16'h0000; bus.b = 16'h0000;
        repeat (4) tick();
        check("ign_done", 32'(bus.done), 32'd1);
        check("ign_sum", 32'(bus.sum), 32'h1010);
        tick();
        check("ign_ready_after_done", 32'(bus.ready), 32'd1);
        bus.start = 1'b0;
        tick();
        check("ign_done_pulses", 32'(done_cnt - d0), 32'd1);

        d0 = done_cnt;
        bus.a = 16'h00FF; bus.b = 16'h0001; bus.carry_in = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        check("clr_ready", 32'(bus.ready), 32'd1);
        check("clr_busy", 32'(bus.busy), 32'd0);
        check("clr_partial_sum", 32'(bus.sum), 32'h0000);
        repeat (6) tick();
        check("clr_no_done", 32'(done_cnt - d0), 32'd0);
        run_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, "after_clr");

        bus.clear = 1'b1; bus.start = 1'b1;
        tick();
        check("clr_prio_ready", 32'(bus.ready), 32'd1);
        bus.clear = 1'b0; bus.start = 1'b0;

        bus.a = 16'h1234; bus.b = 16'h1111; bus.carry_in = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        check("mid_partial", 32'(bus.sum), 32'h0005);
        rst_n = 1'b0;
        #1;
        check("arst_ready", 32'(bus.ready), 32'd1);
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_done", 32'(bus.done), 32'd0);
        check("arst_sum", 32'(bus.sum), 32'd0);
        check("arst_cout", 32'(bus.carry_out), 32'd0);
        rst_n = 1'b1;
        run_op(16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, "after_rst");

        // continuous start: one acceptance every 6 cycles
        bus.a = 16'h0001; bus.b = 16'h0002; bus.carry_in = 1'b0; bus.start = 1'b1;
        for (int c = 0; c < 18; c++) begin
            if (c % 6 == 0) begin
                check("bb_state", 32'({bus.ready, bus.busy, bus.done}), 32'b100);
            end else if (c % 6 == 5) begin
                check("bb_state", 32'({bus.ready, bus.busy, bus.done}), 32'b001);
                check("bb_sum", 32'(bus.sum), 32'h0003);
            end else begin
                check("bb_state", 32'({bus.ready, bus.busy, bus.done}), 32'b010);
            end
            tick();
        end
        bus.start = 1'b0;
        repeat (7) tick();

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
- Sequencer that performs a WIDTH-bit add (a + b + carry_in) using a single 4-bit adder slice, one nibble per clock, LSB nibble first.
- Captures operands on a start handshake, steps a nibble index, and registers the inter-nibble carry.
- Reports completion with a one-cycle done pulse.
- Sits between a wide-operand requester and the shared 4-bit adder datapath; trades latency for area.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- NIBBLES, WIDTH/4, derived local constant; number of RUN cycles. Not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request a new add; accepted only when ready=1
- clear  input  1  synchronous abort; returns the block to IDLE
- a  input  WIDTH  operand A, sampled on the accepting edge only
- b  input  WIDTH  operand B, sampled on the accepting edge only
- carry_in  input  1  initial carry, sampled on the accepting edge only
- ready  output  1  high in IDLE; start is accepted only when high
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse; result valid
- sum  output  WIDTH  registered result
- carry_out  output  1  registered final carry

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous and active-low.
- Reset values:
  - state=IDLE, ready=1, busy=0, done=0.
  - sum=0, carry_out=0.
  - Operand registers, carry register and nibble index all cleared to 0.
- States:
  - IDLE: start=1 and clear=0 at an edge latches a, b and carry_in; clears sum and carry_out to 0; sets idx=0; goes to RUN.
  - RUN: each edge computes {c, s} = a_reg[idx] + b_reg[idx] + carry_reg; writes s into sum[4*idx+3:4*idx]; sets carry_reg=c; increments idx.
    - On the edge where idx==NIBBLES-1, also sets carry_out=c and goes to DONE.
  - DONE: lasts exactly one cycle with done=1, ready=0, busy=0; the next edge goes to IDLE unconditionally.
- Latency: start is sampled at edge E0. Nibble k is written at edge E(k+1). done is high during the cycle after edge E(NIBBLES). This is 4 cycles of RUN for WIDTH=16.
- Outputs:
  - sum and carry_out hold their value from DONE until the next accepted start.
  - Partial sum nibbles are visible during RUN; consumers must qualify the result with done.
- Arithmetic: unsigned modulo 2^WIDTH; carry_out is bit WIDTH of the full sum. Each nibble step is a plain 4-bit add with carry-in and carry-out.
- start when ready=0 (RUN or DONE): ignored and not queued. Operand changes during RUN have no effect.
- Back-to-back operation: start asserted in the DONE cycle is ignored. The earliest next acceptance is the IDLE cycle that follows, so the minimum period is NIBBLES+2 cycles.
- clear=1 in any state: next edge goes to IDLE with no done pulse. sum and carry_out keep their current (possibly partial) value.
- clear has priority over start: start and clear both high in IDLE means start is not accepted.
- rst_n asserted mid-operation: immediate return to the reset values; no done pulse.
- Invariant: exactly one of ready, busy, done is high in every cycle after reset.

Decomposition:
- Shared package holds:
  - the state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - NIBBLE_W=4.
- Natural sub-module: nibble_adder, the purely combinational 4-bit slice {co, s} = x + y + ci. It is instantiated once; the controller muxes operand nibbles into it by idx.
- All sequencing, operand registers and the carry register stay in nibble_serial_adder_ctrl.

Test Plan (WIDTH=16):
- Reset release, then a=16'hFFFF, b=16'h0001, carry_in=0, start pulse -> busy for 4 cycles; done in 5th cycle after start edge; sum=16'h0000, carry_out=1.
- a=16'h1234, b=16'h4321, carry_in=1 -> sum=16'h5556, carry_out=0 at done. Result still held 3 cycles later with start low.
- Start re-asserted during RUN with a=16'h0000, b=16'h0000 -> ignored; first operation completes with its original result; exactly one done pulse.
- clear asserted in 2nd RUN cycle of 16'h00FF+16'h0001 -> IDLE next edge, no done pulse, ready=1. A fresh start of 16'h00FF+16'h0001 then gives sum=16'h0100, carry_out=0.
- rst_n pulsed low mid-RUN -> immediately ready=1, busy=0, done=0, sum=0, carry_out=0. A subsequent 16'h8000+16'h8000 with carry_in=1 gives sum=16'h0001, carry_out=1.
- start held high continuously -> operations accepted every 6 cycles (NIBBLES+2); ready/busy/done are mutually exclusive every cycle.
